// File: rtl/param_stack.sv
`default_nettype none
// ============================================================================
// Module   : param_stack
// Brief    : Parametrised LIFO stack with replace-top, registered peek,
//            occupancy count, almost-full and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_stack #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] top,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  pv_q, pv_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic                  w_wr_en;
    logic [AW-1:0]         w_wr_addr;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        dout_d    = dout_q;
        pv_d      = 1'b0;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = AW'(count_q);
        case ({push, pop})
            2'b10: begin
                if (!w_full) begin
                    w_wr_en = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    top_d   = data_in;
                end else begin
                    w_ovf_evt = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    dout_d  = top_q;
                    pv_d    = 1'b1;
                    count_d = count_q - CNT_W'(1);
                    // top is re-read from the entry below the popped one
                    top_d   = (count_q >= CNT_W'(2)) ? mem_q[AW'(count_q - CNT_W'(2))]
                                                     : '0;
                end else begin
                    w_unf_evt = 1'b1;
                end
            end
            2'b11: begin
                w_wr_en = 1'b1;
                top_d   = data_in;
                if (!w_empty) begin
                    dout_d    = top_q;
                    pv_d      = 1'b1;
                    w_wr_addr = AW'(count_q - CNT_W'(1));
                end else begin
                    count_d   = CNT_W'(1);
                    w_unf_evt = 1'b1;
                end
            end
            default: ;
        endcase
        // a new error event in the clearing cycle keeps the flag set
        ovf_d = (clr_err ? 1'b0 : ovf_q) | w_ovf_evt;
        unf_d = (clr_err ? 1'b0 : unf_q) | w_unf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            top_q   <= '0;
            dout_q  <= '0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            dout_q  <= dout_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            mem_q[w_wr_addr] <= data_in;
        end
    end

    assign data_out    = dout_q;
    assign pop_valid   = pv_q;
    assign top         = top_q;
    assign count       = count_q;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (count_q >= CNT_W'(AF_THRESH));
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
`default_nettype wire
